// File: rtl/pcie_disp_pkg.sv
// pcie_disp_pkg
// Shared definitions for the PCIe display-link ordered-set arbiter:
//   - ordered-set type encodings (0, 6 and 7 are not legal events)
//   - the 16-bit report record {lane, type, count} carried by the report FIFO
//   - widths of the report fields and of the drop counter
//   - os_legal(): true for the five ordered-set types that are captured
package pcie_disp_pkg;

    typedef enum logic [2:0] {
        OS_NONE = 3'd0,
        OS_TS1  = 3'd1,
        OS_TS2  = 3'd2,
        OS_EIOS = 3'd3,
        OS_FTS  = 3'd4,
        OS_SKP  = 3'd5
    } os_type_e;

    localparam int RPT_LANE_W  = 5;
    localparam int RPT_TYPE_W  = 3;
    localparam int RPT_COUNT_W = 8;
    localparam int RPT_W       = RPT_LANE_W + RPT_TYPE_W + RPT_COUNT_W;
    localparam int DROP_W      = 16;

    localparam logic [RPT_COUNT_W-1:0] COUNT_MAX = '1;

    typedef struct packed {
        logic [RPT_LANE_W-1:0]  lane;
        logic [RPT_TYPE_W-1:0]  os_type;
        logic [RPT_COUNT_W-1:0] count;
    } rpt_t;

    function automatic logic os_legal(input logic [RPT_TYPE_W-1:0] t);
        return (t >= OS_TS1) && (t <= OS_SKP);
    endfunction

endpackage

// File: rtl/pcie_disp_rpt_fifo.sv
// pcie_disp_rpt_fifo
// First-word-fall-through FIFO holding serialised lane reports.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (accepted when not full, or full while popping)
//   push_data    WIDTH-bit record to store
//   pop          consume the head entry (ignored while empty)
//   head_data    current head entry, valid while head_valid
//   head_valid   FIFO holds at least one entry
//   full         FIFO holds DEPTH entries
//   level        exact number of entries held
module pcie_disp_rpt_fifo #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic               head_valid,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == LEVEL_W'(DEPTH));
    assign head_valid = (level != '0);
    assign head_data  = mem[rd_ptr[AW-1:0]];

    // A pop on an empty FIFO is ignored, so an entry pushed while empty is
    // simply stored and shows at the head on the following cycle.
    assign do_pop  = pop && head_valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read unless level says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pcie_disp_os_arbiter.sv
// pcie_disp_os_arbiter
// Captures per-lane ordered-set events, coalesces repeats of the same type per
// lane into a saturating count, and round-robin arbitrates pending lanes into
// a report FIFO (one grant per cycle, none while the FIFO is full).
// Ports:
//   Clk, notReset   clock, asynchronous active-low reset
//   Enable          global capture enable
//   LaneSynced      per-lane sync status; low clears the lane's pending slot
//   LaneOsValid     per-lane one-cycle event strobe
//   LaneOsType      per-lane 3-bit type, lane i in bits [3i+2:3i]
//   RptReady        consumer accepts the head report
//   RptValid        head report valid
//   RptLane/Type/Count  head report fields (zero while RptValid is low)
//   FifoLevel       report FIFO occupancy
//   DropCount       saturating count of events lost to type overwrite
module pcie_disp_os_arbiter
    import pcie_disp_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       notReset,
    input  logic                       Enable,
    input  logic [LANES-1:0]           LaneSynced,
    input  logic [LANES-1:0]           LaneOsValid,
    input  logic [3*LANES-1:0]         LaneOsType,
    input  logic                       RptReady,
    output logic                       RptValid,
    output logic [RPT_LANE_W-1:0]      RptLane,
    output logic [RPT_TYPE_W-1:0]      RptType,
    output logic [RPT_COUNT_W-1:0]     RptCount,
    output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
    output logic [DROP_W-1:0]          DropCount
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RPT_LANE_W-1:0] LAST_LANE = RPT_LANE_W'(LANES - 1);

    logic [LANES-1:0]       slot_valid;
    logic [RPT_TYPE_W-1:0]  slot_type  [LANES];
    logic [RPT_COUNT_W-1:0] slot_count [LANES];

    logic [RPT_TYPE_W-1:0]  lane_type  [LANES];
    logic [LANES-1:0]       capture;
    logic [LANES-1:0]       granted;

    logic [RPT_LANE_W-1:0]  rr_ptr;
    logic [RPT_LANE_W-1:0]  grant_lane;
    logic [RPT_LANE_W-1:0]  hi_lane;
    logic [RPT_LANE_W-1:0]  lo_lane;
    logic                   hi_hit;
    logic                   grant_valid;

    rpt_t                   push_rec;
    rpt_t                   head_rec;
    logic                   fifo_full;
    logic                   head_valid;

    logic [DROP_W:0]        drop_add;
    logic [DROP_W:0]        drop_total;

    // Slice the packed type bus and qualify each strobe into a capture.
    always_comb begin
        capture = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_type[i] = LaneOsType[3*i +: 3];
            capture[i]   = Enable && LaneSynced[i] && LaneOsValid[i] && os_legal(lane_type[i]);
        end
    end

    // Round-robin search: the lowest valid lane at or above rr_ptr wins,
    // otherwise wrap to the lowest valid lane overall. Scanning downward lets
    // the last assignment be the lowest match.
    always_comb begin
        hi_hit  = 1'b0;
        hi_lane = '0;
        lo_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (slot_valid[i]) begin
                lo_lane = RPT_LANE_W'(i);
                if (RPT_LANE_W'(i) >= rr_ptr) begin
                    hi_hit  = 1'b1;
                    hi_lane = RPT_LANE_W'(i);
                end
            end
        end
        grant_valid = !fifo_full && (|slot_valid);
        grant_lane  = hi_hit ? hi_lane : lo_lane;
    end

    // The FIFO always takes the slot contents as they stand before this
    // cycle's capture on the same lane.
    always_comb begin
        granted          = '0;
        push_rec         = '0;
        push_rec.lane    = grant_lane;
        for (int i = 0; i < LANES; i++) begin
            if (grant_lane == RPT_LANE_W'(i)) begin
                granted[i]       = grant_valid;
                push_rec.os_type = slot_type[i];
                push_rec.count   = slot_count[i];
            end
        end
    end

    // A different-type capture over a still-pending slot loses the old count.
    // A slot being granted this cycle is not lost, so it never drops.
    always_comb begin
        drop_add = '0;
        for (int i = 0; i < LANES; i++) begin
            if (capture[i] && slot_valid[i] && !granted[i] && (slot_type[i] != lane_type[i])) begin
                drop_add = drop_add + (DROP_W+1)'(slot_count[i]);
            end
        end
        drop_total = {1'b0, DropCount} + drop_add;
    end

    // Round-robin pointer moves just past the lane that was granted.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_lane == LAST_LANE) ? '0 : grant_lane + 1'b1;
        end
    end

    // Pending-slot update. Loss of sync wins over everything; a capture on a
    // granted lane restarts the slot rather than merging into the report.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            slot_valid <= '0;
            for (int i = 0; i < LANES; i++) begin
                slot_type[i]  <= '0;
                slot_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (!LaneSynced[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    slot_valid[i] <= 1'b1;
                    if (!slot_valid[i] || granted[i] || (slot_type[i] != lane_type[i])) begin
                        slot_type[i]  <= lane_type[i];
                        slot_count[i] <= RPT_COUNT_W'(1);
                    end else if (slot_count[i] != COUNT_MAX) begin
                        slot_count[i] <= slot_count[i] + 1'b1;
                    end
                end else if (granted[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Drop counter saturates at all-ones; the carry bit flags overflow.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            DropCount <= '0;
        end else if (drop_total[DROP_W]) begin
            DropCount <= '1;
        end else begin
            DropCount <= drop_total[DROP_W-1:0];
        end
    end

    pcie_disp_rpt_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (RPT_W),
        .LEVEL_W (LEVEL_W)
    ) u_rpt_fifo (
        .clk        (Clk),
        .rst_n      (notReset),
        .push       (grant_valid),
        .push_data  (push_rec),
        .pop        (RptReady),
        .head_data  (head_rec),
        .head_valid (head_valid),
        .full       (fifo_full),
        .level      (FifoLevel)
    );

    // Report fields are forced to zero while empty so outputs are defined
    // from reset even though FIFO storage is not.
    assign RptValid = head_valid;
    assign RptLane  = head_valid ? head_rec.lane    : '0;
    assign RptType  = head_valid ? head_rec.os_type : '0;
    assign RptCount = head_valid ? head_rec.count   : '0;

endmodule

// File: tb/tb_pcie_disp_os_arbiter.sv
// tb_pcie_disp_os_arbiter
// Directed bench for pcie_disp_os_arbiter (LANES=16, FIFO_DEPTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pcie_disp_os_arbiter;

    localparam int LANES      = 16;
    localparam int FIFO_DEPTH = 8;

    logic               Clk = 1'b0;
    logic               notReset;
    logic               Enable;
    logic [LANES-1:0]   LaneSynced;
    logic [LANES-1:0]   LaneOsValid;
    logic [3*LANES-1:0] LaneOsType;
    logic               RptReady;
    logic               RptValid;
    logic [4:0]         RptLane;
    logic [2:0]         RptType;
    logic [7:0]         RptCount;
    logic [3:0]         FifoLevel;
    logic [15:0]        DropCount;

    int errorCount = 0;
    int checkCount = 0;

    always #5 Clk = ~Clk;

    pcie_disp_os_arbiter #(
        .LANES      (LANES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk         (Clk),
        .notReset    (notReset),
        .Enable      (Enable),
        .LaneSynced  (LaneSynced),
        .LaneOsValid (LaneOsValid),
        .LaneOsType  (LaneOsType),
        .RptReady    (RptReady),
        .RptValid    (RptValid),
        .RptLane     (RptLane),
        .RptType     (RptType),
        .RptCount    (RptCount),
        .FifoLevel   (FifoLevel),
        .DropCount   (DropCount)
    );

    // Advance to the next falling edge.
    task automatic tick();
        @(negedge Clk);
    endtask

    // Raise one lane's strobe with the given type; other lanes are untouched.
    task automatic applyStimulus(input int lane, input logic [2:0] osType);
        LaneOsValid[lane]        = 1'b1;
        LaneOsType[3*lane +: 3]  = osType;
    endtask

    task automatic clearStimulus();
        LaneOsValid = '0;
        LaneOsType  = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare the FIFO head against a hand-computed report.
    task automatic checkReport(input string tag, input int lane, input int osType, input int count);
        checkOutput({tag, ".valid"}, 32'(RptValid), 1);
        checkOutput({tag, ".lane"},  32'(RptLane),  lane);
        checkOutput({tag, ".type"},  32'(RptType),  osType);
        checkOutput({tag, ".count"}, 32'(RptCount), count);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".valid"}, 32'(RptValid),  0);
        checkOutput({tag, ".level"}, 32'(FifoLevel), 0);
    endtask

    initial begin
        notReset   = 1'b0;
        Enable     = 1'b1;
        LaneSynced = '1;
        RptReady   = 1'b1;
        clearStimulus();

        // Reset state
        tick();
        tick();
        checkOutput("rst.valid", 32'(RptValid),  0);
        checkOutput("rst.lane",  32'(RptLane),   0);
        checkOutput("rst.count", 32'(RptCount),  0);
        checkOutput("rst.level", 32'(FifoLevel), 0);
        checkOutput("rst.drop",  32'(DropCount), 0);
        notReset = 1'b1;
        tick();

        // Single TS1 on lane 3: report two cycles after the strobe
        applyStimulus(3, 3'd1);
        tick();
        clearStimulus();
        checkOutput("t1.notyet", 32'(RptValid), 0);
        tick();
        checkReport("t1.rpt", 3, 1, 1);
        checkOutput("t1.level", 32'(FifoLevel), 1);
        tick();
        checkIdle("t1.drained");

        // 300 SKPs on lane 0 with the consumer stalled: eight single-count
        // reports fill the FIFO, then the slot coalesces and saturates
        RptReady = 1'b0;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(0, 3'd5);
            tick();
        end
        clearStimulus();
        checkOutput("t2.level", 32'(FifoLevel), FIFO_DEPTH);
        checkReport("t2.head", 0, 5, 1);
        checkOutput("t2.drop", 32'(DropCount), 0);
        RptReady = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkReport($sformatf("t2.drain%0d", k), 0, 5, (k < 8) ? 1 : 255);
        end
        tick();
        checkIdle("t2.empty");

        // Lane 5 TS1 x4 behind a full FIFO, then TS2 overwrites: four dropped
        RptReady = 1'b0;
        for (int l = 8; l < 16; l++) applyStimulus(l, 3'd1);
        tick();
        clearStimulus();
        for (int n = 0; n < 8; n++) tick();
        checkOutput("t3.full", 32'(FifoLevel), FIFO_DEPTH);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(5, 3'd1);
            tick();
        end
        checkOutput("t3.nodrop", 32'(DropCount), 0);
        applyStimulus(5, 3'd2);
        tick();
        clearStimulus();
        checkOutput("t3.drop", 32'(DropCount), 4);
        checkReport("t3.head", 8, 1, 1);
        RptReady = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkReport($sformatf("t3.drain%0d", k), 8 + k, 1, 1);
        end
        tick();
        checkReport("t3.lane5", 5, 2, 1);
        tick();
        checkIdle("t3.empty");

        // Put the round-robin pointer at 2 by serving lane 1
        applyStimulus(1, 3'd1);
        tick();
        clearStimulus();
        tick();
        checkReport("t4.setup", 1, 1, 1);
        tick();
        // Lanes 1, 2, 7 together: served 2, 7, then wrap to 1
        applyStimulus(1, 3'd3);
        applyStimulus(2, 3'd3);
        applyStimulus(7, 3'd3);
        tick();
        clearStimulus();
        tick();
        checkReport("t4.first", 2, 3, 1);
        tick();
        checkReport("t4.second", 7, 3, 1);
        tick();
        checkReport("t4.third", 1, 3, 1);
        tick();
        checkIdle("t4.empty");

        // Lane 4 holds FTS x6 behind a full FIFO; FTS strobed on its grant cycle
        RptReady = 1'b0;
        for (int l = 8; l < 16; l++) applyStimulus(l, 3'd1);
        tick();
        clearStimulus();
        for (int n = 0; n < 8; n++) tick();
        checkOutput("t5.full", 32'(FifoLevel), FIFO_DEPTH);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(4, 3'd4);
            tick();
        end
        clearStimulus();
        checkReport("t5.head", 8, 1, 1);
        RptReady = 1'b1;
        tick();
        checkReport("t5.drain1", 9, 1, 1);
        applyStimulus(4, 3'd4);
        tick();
        clearStimulus();
        for (int k = 2; k <= 7; k++) begin
            if (k > 2) tick();
            checkReport($sformatf("t5.drain%0d", k), 8 + k, 1, 1);
        end
        tick();
        checkReport("t5.lane4a", 4, 4, 6);
        tick();
        checkReport("t5.lane4b", 4, 4, 1);
        tick();
        checkIdle("t5.empty");
        checkOutput("t5.drop", 32'(DropCount), 4);

        // No capture with Enable low
        Enable = 1'b0;
        applyStimulus(3, 3'd1);
        tick();
        tick();
        tick();
        clearStimulus();
        checkIdle("t6.disabled");
        Enable = 1'b1;

        // No capture on an unsynced lane
        LaneSynced[2] = 1'b0;
        applyStimulus(2, 3'd2);
        tick();
        tick();
        clearStimulus();
        tick();
        checkIdle("t6.unsynced");
        LaneSynced = '1;

        // Illegal types 6, 7, 0 are ignored
        applyStimulus(6, 3'd6);
        tick();
        applyStimulus(6, 3'd7);
        tick();
        applyStimulus(6, 3'd0);
        tick();
        clearStimulus();
        tick();
        checkIdle("t6.illegal");

        // Asynchronous reset in the middle of traffic
        RptReady = 1'b0;
        applyStimulus(8, 3'd5);
        applyStimulus(9, 3'd5);
        applyStimulus(10, 3'd5);
        tick();
        clearStimulus();
        tick();
        tick();
        tick();
        checkOutput("t7.level", 32'(FifoLevel), 3);
        checkOutput("t7.valid", 32'(RptValid), 1);
        #2;
        notReset = 1'b0;
        #1;
        checkOutput("t7.rst.valid", 32'(RptValid),  0);
        checkOutput("t7.rst.level", 32'(FifoLevel), 0);
        checkOutput("t7.rst.drop",  32'(DropCount), 0);
        checkOutput("t7.rst.lane",  32'(RptLane),   0);
        tick();
        notReset = 1'b1;
        RptReady = 1'b1;
        tick();
        tick();
        checkIdle("t7.after");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
